// File: rtl/mgt_link_pkg.sv
// Shared definitions for the trigger-link receive path: K-codes, frame geometry,
// link state encoding and the decoded-separator record.
package mgt_link_pkg;

  localparam logic [7:0] K_BC = 8'hBC;
  localparam logic [7:0] K_F7 = 8'hF7;
  localparam logic [7:0] K_FB = 8'hFB;
  localparam logic [7:0] K_FD = 8'hFD;
  localparam logic [7:0] K_FC = 8'hFC;
  localparam logic [7:0] K_1C = 8'h1C;
  localparam logic [7:0] K_3C = 8'h3C;

  localparam int FRAME_WORDS = 4;
  localparam logic [1:0] POS_LAST = 2'(FRAME_WORDS - 1);
  localparam int PAYLOAD_W = 56;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } link_state_t;

  typedef struct packed {
    logic       valid;
    logic       is_seq;
    logic [1:0] bxn;
    logic       overflow;
    logic       bc0;
    logic       resync;
  } sep_info_t;

endpackage

// File: rtl/mgt_sep_decode.sv
// Classifies one received byte plus its K-flag as a frame separator.
// The TTC characters (FC/1C/3C) are only accepted when ALLOW_TTC_CHARS is nonzero.
module mgt_sep_decode
  import mgt_link_pkg::*;
#(
  parameter int ALLOW_TTC_CHARS = 1
) (
  input  logic [7:0] data,
  input  logic       isk,
  output logic       valid,
  output logic       is_seq,
  output logic [1:0] bxn,
  output logic       overflow,
  output logic       bc0,
  output logic       resync
);

  localparam logic TTC_OK = (ALLOW_TTC_CHARS != 0);

  // Separator lookup; anything that is not a K-char or not in the table is invalid
  always_comb begin
    valid    = 1'b0;
    is_seq   = 1'b0;
    bxn      = 2'd0;
    overflow = 1'b0;
    bc0      = 1'b0;
    resync   = 1'b0;
    if (isk) begin
      case (data)
        K_BC: begin valid = 1'b1; is_seq = 1'b1; bxn = 2'd0; end
        K_F7: begin valid = 1'b1; is_seq = 1'b1; bxn = 2'd1; end
        K_FB: begin valid = 1'b1; is_seq = 1'b1; bxn = 2'd2; end
        K_FD: begin valid = 1'b1; is_seq = 1'b1; bxn = 2'd3; end
        K_FC: begin valid = TTC_OK; overflow = TTC_OK; end
        K_1C: begin valid = TTC_OK; bc0 = TTC_OK; end
        K_3C: begin valid = TTC_OK; resync = TTC_OK; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mgt_data_rx.sv
// Trigger-link frame receiver: aligns to 4-word frames, qualifies a lock,
// and delivers the 56-bit payload with separator flags and BX sequence checks.
module mgt_data_rx
  import mgt_link_pkg::*;
#(
  parameter int LOCK_FRAMES     = 4,
  parameter int UNLOCK_ERRS     = 2,
  parameter int ALLOW_TTC_CHARS = 1
) (
  input  logic                 clk_160,
  input  logic                 reset_n,
  input  logic [15:0]          rx_data,
  input  logic [1:0]           rx_isk,
  input  logic                 err_cnt_clr,
  output logic [PAYLOAD_W-1:0] gem_data,
  output logic                 frame_valid,
  output logic                 overflow_o,
  output logic                 bc0_o,
  output logic                 resync_o,
  output logic [1:0]           bxn_lsbs,
  output logic                 bxn_valid,
  output logic                 locked,
  output logic                 seq_err,
  output logic [15:0]          err_cnt
);

  localparam logic [15:0] LOCK_TGT   = 16'(LOCK_FRAMES - 1);
  localparam logic [15:0] UNLOCK_TGT = 16'(UNLOCK_ERRS - 1);

  link_state_t state_q, state_d;
  logic [1:0]  pos_q, pos_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic [7:0]  w0_hi_q;
  logic [15:0] w1_q, w2_q;
  sep_info_t   sep0_q, sep_now;
  logic        prev_seq_q;
  logic [1:0]  prev_bxn_q, bxn_next;
  logic        pos0_ok, data_ok, word_bad;
  logic        load_w0, emit, count_err, seq_break;

  mgt_sep_decode #(.ALLOW_TTC_CHARS(ALLOW_TTC_CHARS)) u_sep (
    .data     (rx_data[7:0]),
    .isk      (rx_isk[0]),
    .valid    (sep_now.valid),
    .is_seq   (sep_now.is_seq),
    .bxn      (sep_now.bxn),
    .overflow (sep_now.overflow),
    .bc0      (sep_now.bc0),
    .resync   (sep_now.resync)
  );

  assign pos0_ok   = (rx_isk == 2'b01) && sep_now.valid;
  assign data_ok   = (rx_isk == 2'b00);
  assign word_bad  = (pos_q == 2'd0) ? !pos0_ok : !data_ok;
  assign bxn_next  = prev_bxn_q + 2'd1;
  assign seq_break = sep0_q.is_seq && prev_seq_q && (sep0_q.bxn != bxn_next);
  assign locked    = (state_q == ST_LOCKED);

  // Link FSM next-state: alignment hunt, lock qualification, and loss-of-lock tracking
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q + 2'd1;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    frame_bad_d = (pos_q == 2'd0) ? word_bad : (frame_bad_q | word_bad);
    load_w0     = 1'b0;
    emit        = 1'b0;
    count_err   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        pos_d       = 2'd0;
        good_cnt_d  = 16'd0;
        bad_cnt_d   = 16'd0;
        frame_bad_d = 1'b0;
        if (pos0_ok) begin
          state_d = ST_CHECK;
          pos_d   = 2'd1;
          load_w0 = 1'b1;
        end
      end
      ST_CHECK: begin
        load_w0 = (pos_q == 2'd0);
        if (word_bad) begin
          state_d    = ST_HUNT;
          pos_d      = 2'd0;
          good_cnt_d = 16'd0;
        end else if (pos_q == POS_LAST) begin
          if (good_cnt_q == LOCK_TGT) begin
            state_d    = ST_LOCKED;
            good_cnt_d = 16'd0;
            bad_cnt_d  = 16'd0;
            emit       = 1'b1;
          end else begin
            good_cnt_d = good_cnt_q + 16'd1;
          end
        end
      end
      ST_LOCKED: begin
        load_w0 = (pos_q == 2'd0);
        if (pos_q == POS_LAST) begin
          if (frame_bad_d) begin
            count_err = 1'b1;
            if (bad_cnt_q == UNLOCK_TGT) begin
              state_d   = ST_HUNT;
              pos_d     = 2'd0;
              bad_cnt_d = 16'd0;
            end else begin
              bad_cnt_d = bad_cnt_q + 16'd1;
            end
          end else begin
            bad_cnt_d = 16'd0;
            emit      = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
        pos_d   = 2'd0;
      end
    endcase
  end

  // State register plus the partial-frame capture and previous-BX history
  always_ff @(posedge clk_160) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      pos_q       <= 2'd0;
      good_cnt_q  <= 16'd0;
      bad_cnt_q   <= 16'd0;
      frame_bad_q <= 1'b0;
      w0_hi_q     <= 8'd0;
      w1_q        <= 16'd0;
      w2_q        <= 16'd0;
      sep0_q      <= '0;
      prev_seq_q  <= 1'b0;
      prev_bxn_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      frame_bad_q <= frame_bad_d;
      if (load_w0) begin
        w0_hi_q <= rx_data[15:8];
        sep0_q  <= sep_now;
      end
      if (state_q != ST_HUNT && pos_q == 2'd1) w1_q <= rx_data;
      if (state_q != ST_HUNT && pos_q == 2'd2) w2_q <= rx_data;
      if (emit) begin
        prev_seq_q <= sep0_q.is_seq;
        if (sep0_q.is_seq) prev_bxn_q <= sep0_q.bxn;
      end else if (state_q != ST_LOCKED) begin
        prev_seq_q <= 1'b0;
      end
    end
  end

  // Frame outputs: payload and BX hold between frames, flags pulse only with frame_valid
  always_ff @(posedge clk_160) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      gem_data    <= '0;
      overflow_o  <= 1'b0;
      bc0_o       <= 1'b0;
      resync_o    <= 1'b0;
      bxn_lsbs    <= 2'd0;
      bxn_valid   <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      frame_valid <= emit;
      overflow_o  <= emit & sep0_q.overflow;
      bc0_o       <= emit & sep0_q.bc0;
      resync_o    <= emit & sep0_q.resync;
      seq_err     <= emit & seq_break;
      if (emit) begin
        gem_data  <= {rx_data, w2_q, w1_q, w0_hi_q};
        bxn_valid <= sep0_q.is_seq;
        if (sep0_q.is_seq) bxn_lsbs <= sep0_q.bxn;
      end
    end
  end

  // Saturating bad-frame counter; a clear request beats a coincident increment
  always_ff @(posedge clk_160) begin
    if (!reset_n) begin
      err_cnt <= 16'd0;
    end else if (err_cnt_clr) begin
      err_cnt <= 16'd0;
    end else if (count_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
